// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   N-way round-robin traffic-light sequencer. Each way runs
//   GREEN -> YELLOW -> ALL-RED, then the next way takes over.
//   Dwell times are counted in ticks from a shared prescaler.
//   A night mode flashes yellow on every way. Flash is only entered at the end of ALL-RED.
//
//   Optional feature macro: TPC_PED_WALK_EN
//     When defined, this adds a pedestrian WALK phase. The phase is requested by
//     ped_req and shown on walk. It also adds the WALK_T parameter.
//
// Ports
//   clock       rising-edge clock
//   reset_n     synchronous reset, active-low
//   tick        count enable; every state change is qualified by it
//   flash       night-mode request (level)
//   ped_req     pedestrian request pulse            (TPC_PED_WALK_EN only)
//   walk        walk lamp                           (TPC_PED_WALK_EN only)
//   light       way i on light[3i+2:3i] = {R,G,Y}
//   active_way  way owning the current phase
//   phase       0=GREEN 1=YELLOW 2=ALLRED 3=FLASH 4=WALK
module traffic_phase_ctrl #(
    parameter int N_WAYS   = 2,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2
`ifdef TPC_PED_WALK_EN
    ,
    parameter int WALK_T   = 10
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  flash,
`ifdef TPC_PED_WALK_EN
    input  logic                  ped_req,
    output logic                  walk,
`endif
    output logic [3*N_WAYS-1:0]   light,
    output logic [2:0]            active_way,
    output logic [2:0]            phase
);

    localparam logic [2:0] PH_GREEN  = 3'd0;
    localparam logic [2:0] PH_YELLOW = 3'd1;
    localparam logic [2:0] PH_ALLRED = 3'd2;
    localparam logic [2:0] PH_FLASH  = 3'd3;
`ifdef TPC_PED_WALK_EN
    localparam logic [2:0] PH_WALK   = 3'd4;
    localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_T - 1);
`endif

    // Counters are loaded with T-1 so that a phase lasts exactly T ticks.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [2:0]       LAST_WAY  = 3'(N_WAYS - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    logic [2:0]       phase_r, phase_nx;
    logic [2:0]       way_r,   way_nx;
    logic [CNT_W-1:0] cnt_r,   cnt_nx;
    logic             tog_r,   tog_nx;
`ifdef TPC_PED_WALK_EN
    logic             ped_r,   ped_nx;
`endif

    logic [2:0] way_next;
    assign way_next = (way_r == LAST_WAY) ? 3'd0 : way_r + 3'd1;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_r <= PH_ALLRED;
            way_r   <= LAST_WAY;
            cnt_r   <= ALLRED_LD;
            tog_r   <= 1'b1;
`ifdef TPC_PED_WALK_EN
            ped_r   <= 1'b0;
`endif
        end else begin
            phase_r <= phase_nx;
            way_r   <= way_nx;
            cnt_r   <= cnt_nx;
            tog_r   <= tog_nx;
`ifdef TPC_PED_WALK_EN
            ped_r   <= ped_nx;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        phase_nx = phase_r;
        way_nx   = way_r;
        cnt_nx   = cnt_r;
        tog_nx   = tog_r;
`ifdef TPC_PED_WALK_EN
        ped_nx   = ped_r;
`endif
        if (tick) begin
            if (phase_r == PH_FLASH) begin
                tog_nx = ~tog_r;
                // Leaving night mode restarts the cycle from a clean
                // all-red, which is owned by the last way so that way 0 is next.
                if (!flash) begin
                    phase_nx = PH_ALLRED;
                    way_nx   = LAST_WAY;
                    cnt_nx   = ALLRED_LD;
                end
            end else if (cnt_r != '0) begin
                cnt_nx = cnt_r - 1'b1;
            end else begin
                case (phase_r)
                    PH_GREEN: begin
                        phase_nx = PH_YELLOW;
                        cnt_nx   = YELLOW_LD;
                    end
                    PH_YELLOW: begin
                        phase_nx = PH_ALLRED;
                        cnt_nx   = ALLRED_LD;
                    end
                    PH_ALLRED: begin
                        // End of all-red is the only safe point to leave
                        // the normal cycle. Flash has priority over walk.
                        if (flash) begin
                            phase_nx = PH_FLASH;
                            tog_nx   = 1'b1;
`ifdef TPC_PED_WALK_EN
                        end else if (ped_r) begin
                            phase_nx = PH_WALK;
                            cnt_nx   = WALK_LD;
`endif
                        end else begin
                            phase_nx = PH_GREEN;
                            way_nx   = way_next;
                            cnt_nx   = GREEN_LD;
                        end
                    end
`ifdef TPC_PED_WALK_EN
                    PH_WALK: begin
                        phase_nx = PH_GREEN;
                        way_nx   = way_next;
                        cnt_nx   = GREEN_LD;
                        ped_nx   = 1'b0;
                    end
`endif
                    default: begin
                        // Unreachable encodings fall back to the reset state.
                        phase_nx = PH_ALLRED;
                        way_nx   = LAST_WAY;
                        cnt_nx   = ALLRED_LD;
                        tog_nx   = 1'b1;
                    end
                endcase
            end
        end
`ifdef TPC_PED_WALK_EN
        // A request arriving while WALK ends is kept for the next round.
        if (ped_req) ped_nx = 1'b1;
`endif
    end

    // Output decode
    always_comb begin
        for (int i = 0; i < N_WAYS; i++) begin
            light[3*i +: 3] = LAMP_RED;
            if (phase_r == PH_FLASH)
                light[3*i +: 3] = {2'b00, tog_r};
            else if (phase_r == PH_GREEN && way_r == 3'(i))
                light[3*i +: 3] = LAMP_GREEN;
            else if (phase_r == PH_YELLOW && way_r == 3'(i))
                light[3*i +: 3] = LAMP_YELLOW;
        end
        active_way = way_r;
        phase      = phase_r;
`ifdef TPC_PED_WALK_EN
        walk       = (phase_r == PH_WALK);
`endif
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
//   Directed bench for traffic_phase_ctrl with N_WAYS=2, GREEN_T=3,
//   YELLOW_T=2, ALLRED_T=1 and WALK_T=2. The expected lamp/phase/way
//   after each clock edge is queued before the edge and checked after it.
module tb_traffic_phase_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       flash;
    logic [5:0] light;
    logic [2:0] active_way;
    logic [2:0] phase;
`ifdef TPC_PED_WALK_EN
    logic       ped_req;
    logic       walk;
`endif

    traffic_phase_ctrl #(
        .N_WAYS  (2),
        .CNT_W   (8),
        .GREEN_T (3),
        .YELLOW_T(2),
        .ALLRED_T(1)
`ifdef TPC_PED_WALK_EN
        ,
        .WALK_T  (2)
`endif
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tick      (tick),
        .flash     (flash),
`ifdef TPC_PED_WALK_EN
        .ped_req   (ped_req),
        .walk      (walk),
`endif
        .light     (light),
        .active_way(active_way),
        .phase     (phase)
    );

    always #5 clock = ~clock;

    localparam logic [5:0] L_AR = 6'b100_100;
    localparam logic [5:0] L_G0 = 6'b100_010;
    localparam logic [5:0] L_Y0 = 6'b100_001;
    localparam logic [5:0] L_G1 = 6'b010_100;
    localparam logic [5:0] L_Y1 = 6'b001_100;
    localparam logic [5:0] L_F1 = 6'b001_001;
    localparam logic [5:0] L_F0 = 6'b000_000;

    typedef struct packed {
        logic [5:0] light;
        logic [2:0] ph;
        logic [2:0] way;
        logic       walk;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Queue the expected outputs, clock once, then compare.
    task automatic cyc(input string tag, input logic [5:0] l, input logic [2:0] p,
                       input logic [2:0] w, input logic wk);
        exp_t e;
        q.push_back('{light: l, ph: p, way: w, walk: wk});
        @(posedge clock);
        #1;
        e = q.pop_front();
        n_assert++;
        assert (light === e.light) else begin
            n_fail++;
            $error("FAIL %s light observed=%b expected=%b", tag, light, e.light);
        end
        n_assert++;
        assert (phase === e.ph) else begin
            n_fail++;
            $error("FAIL %s phase observed=%0d expected=%0d", tag, phase, e.ph);
        end
        n_assert++;
        assert (active_way === e.way) else begin
            n_fail++;
            $error("FAIL %s active_way observed=%0d expected=%0d", tag, active_way, e.way);
        end
`ifdef TPC_PED_WALK_EN
        n_assert++;
        assert (walk === e.walk) else begin
            n_fail++;
            $error("FAIL %s walk observed=%b expected=%b", tag, walk, e.walk);
        end
`endif
    endtask

    task automatic rep(input int n, input string tag, input logic [5:0] l,
                       input logic [2:0] p, input logic [2:0] w, input logic wk);
        for (int i = 0; i < n; i++) cyc(tag, l, p, w, wk);
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b1;
        flash   = 1'b0;
`ifdef TPC_PED_WALK_EN
        ped_req = 1'b0;
`endif
        #1;

        // Reset and the basic two-way cycle
        rep(2, "reset", L_AR, 3'd2, 3'd1, 1'b0);
        reset_n = 1'b1;
        rep(3, "t1_g0", L_G0, 3'd0, 3'd0, 1'b0);
        rep(2, "t1_y0", L_Y0, 3'd1, 3'd0, 1'b0);
        rep(1, "t1_r0", L_AR, 3'd2, 3'd0, 1'b0);
        rep(3, "t1_g1", L_G1, 3'd0, 3'd1, 1'b0);
        rep(2, "t1_y1", L_Y1, 3'd1, 3'd1, 1'b0);
        rep(1, "t1_r1", L_AR, 3'd2, 3'd1, 1'b0);
        rep(1, "t1_wrap", L_G0, 3'd0, 3'd0, 1'b0);

        // Tick gating: first green cycle shown, freeze for 10 cycles
        tick = 1'b0;
        rep(10, "t2_hold", L_G0, 3'd0, 3'd0, 1'b0);
        tick = 1'b1;
        rep(2, "t2_g0", L_G0, 3'd0, 3'd0, 1'b0);
        rep(2, "t2_y0", L_Y0, 3'd1, 3'd0, 1'b0);
        rep(1, "t2_r0", L_AR, 3'd2, 3'd0, 1'b0);
        rep(3, "t2_g1", L_G1, 3'd0, 3'd1, 1'b0);
        rep(2, "t2_y1", L_Y1, 3'd1, 3'd1, 1'b0);
        rep(1, "t2_r1", L_AR, 3'd2, 3'd1, 1'b0);
        rep(1, "t2_g0b", L_G0, 3'd0, 3'd0, 1'b0);

        // Flash requested during way0 green
        flash = 1'b1;
        rep(2, "t3_g0", L_G0, 3'd0, 3'd0, 1'b0);
        rep(2, "t3_y0", L_Y0, 3'd1, 3'd0, 1'b0);
        rep(1, "t3_r0", L_AR, 3'd2, 3'd0, 1'b0);
        cyc("t3_fl1", L_F1, 3'd3, 3'd0, 1'b0);
        cyc("t3_fl0", L_F0, 3'd3, 3'd0, 1'b0);
        tick = 1'b0;
        cyc("t3_flhold", L_F0, 3'd3, 3'd0, 1'b0);
        tick = 1'b1;
        cyc("t3_fl1b", L_F1, 3'd3, 3'd0, 1'b0);
        cyc("t3_fl0b", L_F0, 3'd3, 3'd0, 1'b0);
        flash = 1'b0;
        cyc("t3_exit_ar", L_AR, 3'd2, 3'd1, 1'b0);
        rep(3, "t3_g0", L_G0, 3'd0, 3'd0, 1'b0);

        // Reset during way1 yellow
        rep(2, "t4_y0", L_Y0, 3'd1, 3'd0, 1'b0);
        rep(1, "t4_r0", L_AR, 3'd2, 3'd0, 1'b0);
        rep(3, "t4_g1", L_G1, 3'd0, 3'd1, 1'b0);
        rep(1, "t4_y1", L_Y1, 3'd1, 3'd1, 1'b0);
        reset_n = 1'b0;
        cyc("t4_reset", L_AR, 3'd2, 3'd1, 1'b0);
        reset_n = 1'b1;
        cyc("t4_g0", L_G0, 3'd0, 3'd0, 1'b0);

`ifdef TPC_PED_WALK_EN
        // Pedestrian pulse during way1 green
        rep(2, "t5_g0", L_G0, 3'd0, 3'd0, 1'b0);
        rep(2, "t5_y0", L_Y0, 3'd1, 3'd0, 1'b0);
        rep(1, "t5_r0", L_AR, 3'd2, 3'd0, 1'b0);
        cyc("t5_g1", L_G1, 3'd0, 3'd1, 1'b0);
        ped_req = 1'b1;
        cyc("t5_g1p", L_G1, 3'd0, 3'd1, 1'b0);
        ped_req = 1'b0;
        rep(1, "t5_g1", L_G1, 3'd0, 3'd1, 1'b0);
        rep(2, "t5_y1", L_Y1, 3'd1, 3'd1, 1'b0);
        rep(1, "t5_r1", L_AR, 3'd2, 3'd1, 1'b0);
        rep(2, "t5_walk", L_AR, 3'd4, 3'd1, 1'b1);
        rep(3, "t5_g0", L_G0, 3'd0, 3'd0, 1'b0);
        rep(2, "t5_y0b", L_Y0, 3'd1, 3'd0, 1'b0);
        rep(1, "t5_r0b", L_AR, 3'd2, 3'd0, 1'b0);
        cyc("t5_cleared", L_G1, 3'd0, 3'd1, 1'b0);

        // Flash and pending pedestrian request together
        ped_req = 1'b1;
        flash   = 1'b1;
        cyc("t6_g1", L_G1, 3'd0, 3'd1, 1'b0);
        ped_req = 1'b0;
        rep(1, "t6_g1", L_G1, 3'd0, 3'd1, 1'b0);
        rep(2, "t6_y1", L_Y1, 3'd1, 3'd1, 1'b0);
        rep(1, "t6_r1", L_AR, 3'd2, 3'd1, 1'b0);
        cyc("t6_fl1", L_F1, 3'd3, 3'd1, 1'b0);
        flash = 1'b0;
        cyc("t6_exit_ar", L_AR, 3'd2, 3'd1, 1'b0);
        rep(2, "t6_walk", L_AR, 3'd4, 3'd1, 1'b1);
        cyc("t6_g0", L_G0, 3'd0, 3'd0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
